// File: rtl/apb_arbiter_if.sv
// APB bus bundle used on both sides of apb_arbiter.
// The master modport is the side that issues transfers; the slave modport
// is the side that completes them.
interface apb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic                  pready;
  logic                  perr;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );
endinterface

// File: rtl/apb_arbiter.sv
// Two-master APB arbiter: shares one downstream APB bus between master 0
// and master 1 with round-robin fairness and one transfer in flight.
// The granted master's request is replayed downstream as a fresh
// SETUP/ACCESS pair; the losing master is stalled with pready low.
// Optional macro APB_ARB_TIMEOUT_EN adds an ACCESS-phase watchdog that
// completes a stuck transfer with an error after TIMEOUT_CYCLES cycles.
module apb_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rts,
  apb_arbiter_if.slave  m0,
  apb_arbiter_if.slave  m1,
  apb_arbiter_if.master s
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic                  grant_r;
  logic                  grant_next_s;
  logic                  last_grant_r;
  logic                  last_grant_next_s;
  logic                  timeout_s;
  logic                  rsp_ready_s;
  logic                  rsp_err_s;
  logic [DATA_WIDTH-1:0] rsp_data_s;

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt_r;

  // Count unanswered ACCESS cycles; held at zero in IDLE so every transfer starts fresh.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      wait_cnt_r <= 16'd0;
    end else if (state_r == ST_IDLE) begin
      wait_cnt_r <= 16'd0;
    end else if ((state_r == ST_ACCESS) && !s.pready) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // A slave answering in the limit cycle still completes normally.
  assign timeout_s = (state_r == ST_ACCESS) && !s.pready && (wait_cnt_r == TIMEOUT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // State, current grant and round-robin history.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= next_state_s;
      grant_r      <= grant_next_s;
      last_grant_r <= last_grant_next_s;
    end
  end

  // Arbitration and transfer sequencing.
  always_comb begin
    next_state_s      = state_r;
    grant_next_s      = grant_r;
    last_grant_next_s = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (m0.psel && m1.psel) begin
          grant_next_s = ~last_grant_r;
          next_state_s = ST_SETUP;
        end else if (m0.psel) begin
          grant_next_s = 1'b0;
          next_state_s = ST_SETUP;
        end else if (m1.psel) begin
          grant_next_s = 1'b1;
          next_state_s = ST_SETUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        next_state_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        // History advances even when the master has abandoned the transfer.
        if (s.pready || timeout_s) begin
          last_grant_next_s = grant_r;
          next_state_s      = ST_IDLE;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Downstream bus: unregistered mux of the granted master while a transfer is open.
  always_comb begin
    s.psel    = 1'b0;
    s.penable = 1'b0;
    s.pwrite  = 1'b0;
    s.paddr   = {ADDR_WIDTH{1'b0}};
    s.pdata   = {DATA_WIDTH{1'b0}};
    s.pstb    = 4'b0000;
    if (state_r != ST_IDLE) begin
      s.psel    = 1'b1;
      s.penable = (state_r == ST_ACCESS);
      if (grant_r) begin
        s.pwrite = m1.pwrite;
        s.paddr  = m1.paddr;
        s.pdata  = m1.pdata;
        s.pstb   = m1.pstb;
      end else begin
        s.pwrite = m0.pwrite;
        s.paddr  = m0.paddr;
        s.pdata  = m0.pdata;
        s.pstb   = m0.pstb;
      end
    end else begin
      s.psel    = 1'b0;
      s.penable = 1'b0;
    end
  end

  // Completion response: slave result, or a synthesized error on timeout.
  always_comb begin
    rsp_ready_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_data_s  = {DATA_WIDTH{1'b0}};
    if ((state_r == ST_ACCESS) && s.pready) begin
      rsp_ready_s = 1'b1;
      rsp_err_s   = s.perr;
      rsp_data_s  = s.prdata;
    end else if (timeout_s) begin
      rsp_ready_s = 1'b1;
      rsp_err_s   = 1'b1;
      rsp_data_s  = {DATA_WIDTH{1'b0}};
    end else begin
      rsp_ready_s = 1'b0;
    end
  end

  // Route the response to the granted master only while it still requests.
  always_comb begin
    m0.pready = 1'b0;
    m0.perr   = 1'b0;
    m0.prdata = {DATA_WIDTH{1'b0}};
    m1.pready = 1'b0;
    m1.perr   = 1'b0;
    m1.prdata = {DATA_WIDTH{1'b0}};
    if (!grant_r && m0.psel) begin
      m0.pready = rsp_ready_s;
      m0.perr   = rsp_err_s;
      m0.prdata = rsp_data_s;
    end else if (grant_r && m1.psel) begin
      m1.pready = rsp_ready_s;
      m1.perr   = rsp_err_s;
      m1.prdata = rsp_data_s;
    end else begin
      m0.pready = 1'b0;
      m1.pready = 1'b0;
    end
  end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Two-master to one-slave-bus APB arbiter; shares the single APB fabric (decoder, sram, uart) between the cpu and a second requester (DMA/debug).
- Sits between the masters and the APB decoder; re-issues the granted master's transfer downstream with a fresh SETUP/ACCESS sequence.
- Stalls the losing master by holding its pready low.
- Round-robin fairness; one outstanding transfer at a time.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit (used only with APB_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rts  in  1  reset, asynchronous, active-high
m0_paddr  in  ADDR_WIDTH  master 0 address
m0_pdata  in  DATA_WIDTH  master 0 write data
m0_prdata  out  DATA_WIDTH  master 0 read data
m0_psel  in  1  master 0 select (request)
m0_penable  in  1  master 0 enable
m0_pwrite  in  1  master 0 write
m0_pstb  in  4  master 0 byte strobes
m0_pready  out  1  master 0 transfer complete
m0_perr  out  1  master 0 error, valid with m0_pready
m1_* (paddr, pdata, prdata, psel, penable, pwrite, pstb, pready, perr): same as m0_*, for master 1
s_paddr  out  ADDR_WIDTH  bus address
s_pdata  out  DATA_WIDTH  bus write data
s_prdata  in  DATA_WIDTH  bus read data
s_psel  out  1  bus select
s_penable  out  1  bus enable
s_pwrite  out  1  bus write
s_pstb  out  4  bus strobes
s_pready  in  1  bus ready
s_perr  in  1  bus error

Behaviour:
- FSM states: IDLE, SETUP, ACCESS. Registers: state, grant (0/1), last_grant (0/1).
- Reset (async, rts=1): state=IDLE, grant=0, last_grant=1. All outputs 0: s_psel, s_penable, s_pwrite, s_paddr, s_pdata, s_pstb, m0/m1_pready, m0/m1_perr, m0/m1_prdata.
- IDLE:
  - No mX_psel: stay IDLE.
  - One mX_psel high: grant=X, go to SETUP.
  - Both high: grant = !last_grant, go to SETUP.
- SETUP: s_psel=1, s_penable=0; s_paddr/pdata/pwrite/pstb are combinational muxes of the granted master's inputs. Always go to ACCESS next cycle.
- ACCESS:
  - s_psel=1, s_penable=1.
  - While s_pready=0: hold.
  - When s_pready=1 (same cycle, combinational): mG_pready=1, mG_perr=s_perr, mG_prdata=s_prdata. Then last_grant=grant, next state IDLE.
- Non-granted master: pready=0, perr=0, prdata=0 at all times.
- IDLE state: all s_* outputs 0.
- Minimum latency, master psel rise (cycle N) to its pready: cycle N+2, with zero-wait slave. Each slave wait state adds one cycle.
- Back-to-back: the cycle after completion is IDLE. A master still (or again) holding psel in that IDLE cycle wins arbitration per round-robin. Max bus occupancy is one transfer per 3 cycles.
- Starvation-free: with both masters continuously requesting, grants strictly alternate 0,1,0,1...
- Master drops psel while granted (protocol violation): downstream transfer still runs to s_pready; result discarded (pready not asserted to any master).
- Reset mid-transfer: s_psel/s_penable drop asynchronously. The slave transfer is abandoned; masters restart after reset.
- Downstream address/data are not registered. Masters must hold their signals stable until their pready, per APB.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter, cleared on SETUP entry, increments each ACCESS cycle with s_pready=0.
  - When the counter reaches TIMEOUT_CYCLES-1 with s_pready still 0: that cycle assert mG_pready=1, mG_perr=1, mG_prdata=0.
  - Update last_grant; next state IDLE (downstream psel/penable drop).
  - A simultaneous s_pready=1 wins over timeout (normal completion).
- Undefined: no counter; ACCESS waits indefinitely for s_pready.

Test Plan:
- Reset: rts=1 mid-ACCESS -> s_psel=0, s_penable=0, all pready=0 immediately (before next clk edge); after release, first contended request goes to master 0.
- Single master 0 read, addr 0x00000010, slave ready immediately, s_prdata=0xDEADBEEF -> s_psel high cycles N+1..N+2, s_penable high N+2, m0_pready=1 with m0_prdata=0xDEADBEEF at N+2, m1_pready=0 throughout.
- Both masters request at cycle N (m0 write 0x11111111 to 0x0, m1 write 0x22222222 to 0x4) -> m0 served first (N+2), m1 SETUP at N+4, completes N+5; s_pdata matches each in order.
- Both masters request continuously for 6 transfers -> grant order 0,1,0,1,0,1; no master waits more than one foreign transfer.
- Master 1 read with slave inserting 3 wait states and s_perr=1 on completion -> m1_pready=1, m1_perr=1 at N+5; m0 stalled with pready=0 meanwhile.
- (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) slave never ready -> m0_pready=1, m0_perr=1, m0_prdata=0 on the 8th ACCESS cycle; next cycle s_psel=0; waiting m1 granted next.
